ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single core-side RAM port between the instruction fetch unit (IF requester) and the load/store unit (MEM requester).
- Grants one transaction at a time and registers the winning request onto the downstream valid/ready port.
- Routes the completion back to the granted requester.
- MEM has priority; a streak limiter keeps IF from starving; an IF flush input discards stale fetch responses after a branch, jump or interrupt.

Parameters:
- MAX_MEM_STREAK, 4: max consecutive MEM grants while IF is pending before IF is forced; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_if_valid  in  1  IF request; held until o_if_ready
- i_if_addr  in  64  IF fetch address
- i_if_flush  in  1  discard the in-flight IF response
- o_if_ready  out  1  IF completion pulse; o_if_rdata valid this cycle
- o_if_rdata  out  32  instruction word
- i_mem_valid  in  1  MEM request; held until o_mem_ready
- i_mem_wen  in  1  1 = write, 0 = read
- i_mem_addr  in  64  MEM address
- i_mem_wdata  in  64  write data
- i_mem_wmask  in  8  byte write mask
- i_mem_size  in  3  access size code
- o_mem_ready  out  1  MEM completion pulse
- o_mem_rdata  out  64  read data
- o_ram_valid  out  1  downstream request valid
- o_ram_wen  out  1  downstream write enable
- o_ram_addr  out  64  downstream address
- o_ram_wdata  out  64  downstream write data
- o_ram_wmask  out  8  downstream byte mask
- o_ram_size  out  3  downstream size code
- i_ram_ready  in  1  downstream completion; i_ram_rdata valid this cycle
- i_ram_rdata  in  64  downstream read data

Behaviour:
Reset (rst_n = 0 at a clk edge):
- state = IDLE; o_ram_valid = 0; o_ram_wen = 0; o_ram_addr = 0; o_ram_wdata = 0; o_ram_wmask = 0; o_ram_size = 0.
- drop flag = 0; streak counter = 0.
- Reset mid-transaction abandons the transaction with no completion pulse; the downstream side is reset at the same time.
- o_if_ready = 0 and o_mem_ready = 0 during reset.

States: IDLE, BUSY_IF, BUSY_MEM.

IDLE, choosing a winner:
- Neither requester valid: stay in IDLE.
- Only one requester valid: it wins.
- Both valid: MEM wins, unless the streak counter equals MAX_MEM_STREAK, in which case IF wins.

IDLE, registering the winner (next clk edge):
- o_ram_* loaded from the winner; o_ram_valid <= 1; state <= BUSY_IF or BUSY_MEM.
- IF grant drives: wen = 0, wmask = 0, wdata = 0, size = 3'b010, addr = i_if_addr.

Streak counter:
- On a MEM grant while i_if_valid = 1: counter increments, saturating at MAX_MEM_STREAK.
- On a MEM grant while i_if_valid = 0: counter clears.
- On any IF grant: counter clears.

BUSY states:
- o_ram_* held stable; later changes on requester inputs are ignored.
- The cycle i_ram_ready = 1: o_ram_valid <= 0 and state <= IDLE at the next edge.
- Minimum spacing is 2 cycles per transaction; the next grant is decided in IDLE.

Completion (combinational, same cycle as i_ram_ready):
- o_mem_ready = (state == BUSY_MEM) & i_ram_ready.
- o_mem_rdata = i_ram_rdata, undefined (passed through) outside completion.
- o_if_ready = (state == BUSY_IF) & i_ram_ready & ~drop & ~i_if_flush.
- o_if_rdata = o_ram_addr[2] ? i_ram_rdata[63:32] : i_ram_rdata[31:0].

Flush:
- i_if_flush in BUSY_IF sets drop; drop clears when the BUSY_IF transaction completes.
- i_if_flush in IDLE or BUSY_MEM has no effect.
- Flush in the same cycle as i_ram_ready suppresses that completion.

Other rules:
- i_ram_ready while IDLE is ignored.
- A requester that drops valid before its grant is simply not granted.

Test Plan:
1. Reset, then IF-only request at 0x8000_0000 with downstream ready 2 cycles after o_ram_valid and rdata 0x1111_2222_3333_4444 -> o_ram_size = 3'b010, o_ram_addr = 0x8000_0000; o_if_ready pulses 1 cycle with o_if_rdata = 0x3333_4444. Repeat at 0x8000_0004 -> o_if_rdata = 0x1111_2222.
2. IF and MEM valid in the same IDLE cycle, MEM write addr 0x100, wmask 0xFF -> MEM granted first with o_ram_wen = 1; IF granted in the IDLE after MEM completes.
3. MEM held continuously valid, IF held valid, MAX_MEM_STREAK = 4 -> exactly 4 MEM grants, then 1 IF grant, then MEM resumes.
4. i_if_flush pulsed in BUSY_IF before i_ram_ready -> no o_if_ready for that fetch. A new IF request afterward completes normally.
5. i_if_flush asserted in the same cycle as i_ram_ready -> o_if_ready stays 0; state returns to IDLE.
6. rst_n low during BUSY_MEM -> next cycle o_ram_valid = 0, state IDLE, and no o_mem_ready pulse even if i_ram_ready arrives.

Source files
------------

// File: rtl/ram_arbiter.sv
// Arbitrates the shared core-side RAM port between instruction fetch (IF) and load/store (MEM).
// MEM has priority, bounded by a streak limiter; IF responses can be dropped after a flush.
module ram_arbiter #(
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_valid,
  input  logic [63:0] i_if_addr,
  input  logic        i_if_flush,
  output logic        o_if_ready,
  output logic [31:0] o_if_rdata,
  input  logic        i_mem_valid,
  input  logic        i_mem_wen,
  input  logic [63:0] i_mem_addr,
  input  logic [63:0] i_mem_wdata,
  input  logic [7:0]  i_mem_wmask,
  input  logic [2:0]  i_mem_size,
  output logic        o_mem_ready,
  output logic [63:0] o_mem_rdata,
  output logic        o_ram_valid,
  output logic        o_ram_wen,
  output logic [63:0] o_ram_addr,
  output logic [63:0] o_ram_wdata,
  output logic [7:0]  o_ram_wmask,
  output logic [2:0]  o_ram_size,
  input  logic        i_ram_ready,
  input  logic [63:0] i_ram_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_MEM_STREAK);

  state_t     state_q, state_d;
  logic       drop_q;
  logic [3:0] streak_q;
  logic       grant_mem, grant_if;

  // MEM wins ties unless IF has been passed over MAX_MEM_STREAK times in a row
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        grant_mem = i_mem_valid & (~i_if_valid | (streak_q != STREAK_MAX));
        grant_if  = i_if_valid & ~grant_mem;
        if (grant_mem)     state_d = BUSY_MEM;
        else if (grant_if) state_d = BUSY_IF;
      end
      BUSY_IF, BUSY_MEM: begin
        if (i_ram_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q <= 4'd0;
    end else if (grant_mem) begin
      if (!i_if_valid)                streak_q <= 4'd0;
      else if (streak_q != STREAK_MAX) streak_q <= streak_q + 4'd1;
    end else if (grant_if) begin
      streak_q <= 4'd0;
    end
  end

  // Completion takes precedence so a flush coinciding with ready leaves drop clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else if (state_q == BUSY_IF) begin
      if (i_ram_ready)     drop_q <= 1'b0;
      else if (i_if_flush) drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_ram_valid <= 1'b0;
      o_ram_wen   <= 1'b0;
      o_ram_addr  <= 64'd0;
      o_ram_wdata <= 64'd0;
      o_ram_wmask <= 8'd0;
      o_ram_size  <= 3'd0;
    end else if (grant_mem) begin
      o_ram_valid <= 1'b1;
      o_ram_wen   <= i_mem_wen;
      o_ram_addr  <= i_mem_addr;
      o_ram_wdata <= i_mem_wdata;
      o_ram_wmask <= i_mem_wmask;
      o_ram_size  <= i_mem_size;
    end else if (grant_if) begin
      o_ram_valid <= 1'b1;
      o_ram_wen   <= 1'b0;
      o_ram_addr  <= i_if_addr;
      o_ram_wdata <= 64'd0;
      o_ram_wmask <= 8'd0;
      o_ram_size  <= 3'b010;
    end else if ((state_q != IDLE) && i_ram_ready) begin
      o_ram_valid <= 1'b0;
    end
  end

  assign o_mem_ready = rst_n & (state_q == BUSY_MEM) & i_ram_ready;
  assign o_mem_rdata = i_ram_rdata;
  assign o_if_ready  = rst_n & (state_q == BUSY_IF) & i_ram_ready & ~drop_q & ~i_if_flush;
  assign o_if_rdata  = o_ram_addr[2] ? i_ram_rdata[63:32] : i_ram_rdata[31:0];

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a queue holds the expected grant order and completion
// outcome; a small downstream model answers each grant and checks it against the queue.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_if_valid, i_if_flush, i_mem_valid, i_mem_wen, i_ram_ready;
  logic [63:0] i_if_addr, i_mem_addr, i_mem_wdata, i_ram_rdata;
  logic [7:0]  i_mem_wmask;
  logic [2:0]  i_mem_size;
  logic        o_if_ready, o_mem_ready, o_ram_valid, o_ram_wen;
  logic [31:0] o_if_rdata;
  logic [63:0] o_mem_rdata, o_ram_addr, o_ram_wdata;
  logic [7:0]  o_ram_wmask;
  logic [2:0]  o_ram_size;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_mem;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [2:0]  size;
    logic        done;
  } exp_t;

  exp_t q[$];

  ram_arbiter #(.MAX_MEM_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_valid(i_if_valid), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_ready(o_if_ready), .o_if_rdata(o_if_rdata),
    .i_mem_valid(i_mem_valid), .i_mem_wen(i_mem_wen), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_wmask(i_mem_wmask), .i_mem_size(i_mem_size),
    .o_mem_ready(o_mem_ready), .o_mem_rdata(o_mem_rdata),
    .o_ram_valid(o_ram_valid), .o_ram_wen(o_ram_wen), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .o_ram_wmask(o_ram_wmask), .o_ram_size(o_ram_size),
    .i_ram_ready(i_ram_ready), .i_ram_rdata(i_ram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_if(input logic [63:0] addr, input logic done);
    exp_t e;
    e.is_mem = 1'b0; e.wen = 1'b0; e.addr = addr; e.wdata = 64'd0;
    e.wmask = 8'd0; e.size = 3'b010; e.done = done;
    return e;
  endfunction

  function automatic exp_t mk_mem(input logic wen, input logic [63:0] addr,
                                  input logic [63:0] wdata, input logic [7:0] wmask,
                                  input logic [2:0] size);
    exp_t e;
    e.is_mem = 1'b1; e.wen = wen; e.addr = addr; e.wdata = wdata;
    e.wmask = wmask; e.size = size; e.done = 1'b1;
    return e;
  endfunction

  // Waits for the next downstream request and checks it against the head of the queue
  task automatic wait_grant(output exp_t e);
    int n = 0;
    while (!o_ram_valid && n < 20) begin
      step();
      n++;
    end
    chk("grant_seen", o_ram_valid, 1'b1);
    if (q.size() == 0) begin
      chk("queue_nonempty", 64'(q.size()), 64'd1);
      e = mk_if(64'd0, 1'b0);
    end else begin
      e = q.pop_front();
    end
    chk("ram_addr",  o_ram_addr,  e.addr);
    chk("ram_wen",   o_ram_wen,   e.wen);
    chk("ram_size",  o_ram_size,  e.size);
    chk("ram_wmask", o_ram_wmask, e.wmask);
    chk("ram_wdata", o_ram_wdata, e.wdata);
  endtask

  task automatic serve(input int delay, input logic [63:0] rdata,
                       input bit flush_pulse, input bit flush_ready);
    exp_t e;
    logic [31:0] exp_word;
    wait_grant(e);
    for (int i = 0; i < delay; i++) begin
      i_if_flush = flush_pulse && (i == 0);
      step();
      i_if_flush = 1'b0;
      chk("hold_valid", o_ram_valid, 1'b1);
      chk("hold_addr",  o_ram_addr,  e.addr);
    end
    i_ram_ready = 1'b1;
    i_ram_rdata = rdata;
    i_if_flush  = flush_ready;
    #1;
    chk("if_ready",  o_if_ready,  !e.is_mem && e.done);
    chk("mem_ready", o_mem_ready, e.is_mem);
    exp_word = e.addr[2] ? rdata[63:32] : rdata[31:0];
    if (e.is_mem)    chk("mem_rdata", o_mem_rdata, rdata);
    else if (e.done) chk("if_rdata",  o_if_rdata,  exp_word);
    step();
    i_ram_ready = 1'b0;
    i_if_flush  = 1'b0;
    #1;
    chk("valid_drop", o_ram_valid, 1'b0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    i_if_valid = 0; i_if_flush = 0; i_if_addr = 0;
    i_mem_valid = 0; i_mem_wen = 0; i_mem_addr = 0; i_mem_wdata = 0;
    i_mem_wmask = 0; i_mem_size = 0; i_ram_ready = 0; i_ram_rdata = 0;
    step(); step();
    chk("rst_valid", o_ram_valid, 1'b0);
    chk("rst_addr",  o_ram_addr,  64'd0);
    chk("rst_wdata", o_ram_wdata, 64'd0);
    chk("rst_wmask", o_ram_wmask, 8'd0);
    chk("rst_size",  o_ram_size,  3'd0);
    chk("rst_wen",   o_ram_wen,   1'b0);
    rst_n = 1'b1;
    step();

    // IF-only fetches, low then high word
    i_if_valid = 1'b1; i_if_addr = 64'h8000_0000;
    q.push_back(mk_if(64'h8000_0000, 1'b1));
    serve(2, 64'h1111_2222_3333_4444, 0, 0);
    i_if_addr = 64'h8000_0004;
    q.push_back(mk_if(64'h8000_0004, 1'b1));
    serve(2, 64'h1111_2222_3333_4444, 0, 0);
    i_if_valid = 1'b0;

    // Simultaneous requests: MEM write first, then IF
    i_if_valid = 1'b1; i_if_addr = 64'h8000_0020;
    i_mem_valid = 1'b1; i_mem_wen = 1'b1; i_mem_addr = 64'h100;
    i_mem_wdata = 64'hDEAD_BEEF_0123_4567; i_mem_wmask = 8'hFF; i_mem_size = 3'b011;
    q.push_back(mk_mem(1'b1, 64'h100, 64'hDEAD_BEEF_0123_4567, 8'hFF, 3'b011));
    q.push_back(mk_if(64'h8000_0020, 1'b1));
    serve(1, 64'h0, 0, 0);
    i_mem_valid = 1'b0;
    serve(1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
    i_if_valid = 1'b0;

    // Streak limiter: four MEM grants, one IF, then MEM again
    i_if_valid = 1'b1; i_if_addr = 64'h8000_0008;
    i_mem_valid = 1'b1; i_mem_wen = 1'b0; i_mem_addr = 64'h200;
    i_mem_wdata = 64'd0; i_mem_wmask = 8'd0; i_mem_size = 3'b011;
    for (int i = 0; i < 4; i++) q.push_back(mk_mem(1'b0, 64'h200, 64'd0, 8'd0, 3'b011));
    q.push_back(mk_if(64'h8000_0008, 1'b1));
    q.push_back(mk_mem(1'b0, 64'h200, 64'd0, 8'd0, 3'b011));
    for (int i = 0; i < 6; i++) serve(0, 64'h5555_6666_7777_0000 + 64'(i), 0, 0);
    i_if_valid = 1'b0; i_mem_valid = 1'b0;

    // Flush before completion drops the response; next fetch completes normally
    i_if_valid = 1'b1; i_if_addr = 64'h8000_0010;
    q.push_back(mk_if(64'h8000_0010, 1'b0));
    serve(2, 64'h1234_5678_9ABC_DEF0, 1, 0);
    i_if_addr = 64'h8000_0014;
    q.push_back(mk_if(64'h8000_0014, 1'b1));
    serve(1, 64'h1234_5678_9ABC_DEF0, 0, 0);
    i_if_valid = 1'b0;

    // Flush coincident with ready suppresses that completion only
    i_if_valid = 1'b1; i_if_addr = 64'h8000_0018;
    q.push_back(mk_if(64'h8000_0018, 1'b0));
    serve(1, 64'h0F0F_0F0F_F0F0_F0F0, 0, 1);
    i_if_addr = 64'h8000_001C;
    q.push_back(mk_if(64'h8000_001C, 1'b1));
    serve(0, 64'h0F0F_0F0F_F0F0_F0F0, 0, 0);
    i_if_valid = 1'b0;

    // Reset in the middle of a MEM transaction
    i_mem_valid = 1'b1; i_mem_wen = 1'b1; i_mem_addr = 64'h300;
    i_mem_wdata = 64'h0000_0000_CAFE_F00D; i_mem_wmask = 8'h0F; i_mem_size = 3'b010;
    q.push_back(mk_mem(1'b1, 64'h300, 64'h0000_0000_CAFE_F00D, 8'h0F, 3'b010));
    wait_grant(e);
    rst_n = 1'b0;
    i_ram_ready = 1'b1;
    #1;
    chk("rst_mem_ready", o_mem_ready, 1'b0);
    step();
    chk("rst_mid_valid", o_ram_valid, 1'b0);
    chk("rst_mid_addr",  o_ram_addr,  64'd0);
    chk("rst_mid_mrdy",  o_mem_ready, 1'b0);
    rst_n = 1'b1;
    i_mem_valid = 1'b0;
    #1;
    chk("post_rst_mrdy", o_mem_ready, 1'b0);
    step();
    i_ram_ready = 1'b0;
    step();
    chk("post_rst_idle", o_ram_valid, 1'b0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
